// File: rtl/det_event_window_counter.sv
// Counts detector pulses over back-to-back windows of WINDOW enabled cycles and
// latches count/alarm/saturation at each close. Optional macro: DET_ALARM_STICKY_EN.
module det_event_window_counter #(
  parameter int CNT_W  = 8,
  parameter int WINDOW = 16,
  parameter int THRESH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             det_in,
  input  logic             clear,
  output logic [CNT_W-1:0] win_count,
  output logic             win_done,
  output logic             alarm,
  output logic             sat
);

  localparam int                TICK_W    = $clog2(WINDOW);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  THRESH_C  = CNT_W'(THRESH);

  typedef enum logic {
    RUN   = 1'b0,
    PAUSE = 1'b1
  } mode_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    if (inc && (v != CNT_MAX)) begin
      return v + CNT_W'(1);
    end else begin
      return v;
    end
  endfunction

  mode_t             mode_s;
  logic [TICK_W-1:0] tick_r, tick_n;
  logic [CNT_W-1:0]  acc_r, acc_n;
  logic [CNT_W-1:0]  win_count_r, win_count_n;
  logic              win_done_r, win_done_n;
  logic              alarm_r, alarm_n;
  logic              sat_r, sat_n;
  logic [CNT_W-1:0]  final_s;
  logic              alarm_hit_s;

  // Mode follows en every cycle; no history is needed to decide it.
  always_comb begin
    if (en) begin
      mode_s = RUN;
    end else begin
      mode_s = PAUSE;
    end
  end

  // Next-state for window progress, accumulation and close-time latching.
  always_comb begin
    tick_n      = tick_r;
    acc_n       = acc_r;
    win_count_n = win_count_r;
    win_done_n  = 1'b0;
    alarm_n     = alarm_r;
    sat_n       = sat_r;
    final_s     = sat_inc(acc_r, det_in);
    alarm_hit_s = (final_s >= THRESH_C);
    if (clear) begin
      tick_n  = '0;
      acc_n   = '0;
      alarm_n = 1'b0;
    end else begin
      case (mode_s)
        RUN: begin
          if (tick_r == TICK_LAST) begin
            // The closing cycle's det_in belongs to the window being closed.
            win_count_n = final_s;
            sat_n       = (final_s == CNT_MAX);
            win_done_n  = 1'b1;
            tick_n      = '0;
            acc_n       = '0;
`ifdef DET_ALARM_STICKY_EN
            alarm_n     = alarm_r | alarm_hit_s;
`else
            alarm_n     = alarm_hit_s;
`endif
          end else begin
            tick_n = tick_r + TICK_W'(1);
            acc_n  = final_s;
          end
        end
        PAUSE: begin
          win_done_n = 1'b0;
        end
        default: begin
          win_done_n = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; synchronous reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_r      <= '0;
      acc_r       <= '0;
      win_count_r <= '0;
      win_done_r  <= 1'b0;
      alarm_r     <= 1'b0;
      sat_r       <= 1'b0;
    end else begin
      tick_r      <= tick_n;
      acc_r       <= acc_n;
      win_count_r <= win_count_n;
      win_done_r  <= win_done_n;
      alarm_r     <= alarm_n;
      sat_r       <= sat_n;
    end
  end

  assign win_count = win_count_r;
  assign win_done  = win_done_r;
  assign alarm     = alarm_r;
  assign sat       = sat_r;

endmodule
